exec_pipelined: RTL

- Next-generation execute stage with registered EX/MEM output.
- Width-parametrised ALU with an extended op set, two-source operand forwarding and an iterative multi-cycle multiplier.
- Sits between the ID/EX and MEM stages.
- Exports a busy signal so the hazard logic stalls IF/ID/ID-EX while a multiply is in flight.

---
 rtl/exec_pipelined_if.sv | 52 +++++
 rtl/exec_pipelined.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/exec_pipelined_if.sv
// exec_pipelined_if
//   Bundle between the ID/EX register, the MEM/WB forwarding source and the
//   execute stage's EX/MEM output register.
//   master : drives the ID/EX instruction fields and MEM/WB writeback info,
//            observes busy and the EX/MEM register.
//   slave  : the execute stage itself.
//   Signals:
//     in_valid, flush                      instruction handshake / kill
//     readData1, readData2, address        operand sources
//     ctrlAluSrc, aluCtrl                  operand B select, ALU opcode
//     regWrite_IDEX, rs/rt/rd_IDEX         ID/EX register indices and write enable
//     rd_MEMWB, regWrite_MEMWB, valueToWB  MEM/WB forwarding source
//     busy                                 execute stage stalls upstream
//     valid/result/rd/regWrite/zero_EXMEM  registered EX/MEM outputs
interface exec_pipelined_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_W  = 5
) ();
   logic              in_valid;
   logic              flush;
   logic [DATA_W-1:0] readData1;
   logic [DATA_W-1:0] readData2;
   logic [DATA_W-1:0] address;
   logic              ctrlAluSrc;
   logic [2:0]        aluCtrl;
   logic              regWrite_IDEX;
   logic [REG_W-1:0]  rs_IDEX;
   logic [REG_W-1:0]  rt_IDEX;
   logic [REG_W-1:0]  rd_IDEX;
   logic [REG_W-1:0]  rd_MEMWB;
   logic              regWrite_MEMWB;
   logic [DATA_W-1:0] valueToWB;

   logic              busy;
   logic              valid_EXMEM;
   logic [DATA_W-1:0] result_EXMEM;
   logic [REG_W-1:0]  rd_EXMEM;
   logic              regWrite_EXMEM;
   logic              zero_EXMEM;

   modport master (
      output in_valid, flush, readData1, readData2, address, ctrlAluSrc, aluCtrl,
             regWrite_IDEX, rs_IDEX, rt_IDEX, rd_IDEX, rd_MEMWB, regWrite_MEMWB, valueToWB,
      input  busy, valid_EXMEM, result_EXMEM, rd_EXMEM, regWrite_EXMEM, zero_EXMEM
   );

   modport slave (
      input  in_valid, flush, readData1, readData2, address, ctrlAluSrc, aluCtrl,
             regWrite_IDEX, rs_IDEX, rt_IDEX, rd_IDEX, rd_MEMWB, regWrite_MEMWB, valueToWB,
      output busy, valid_EXMEM, result_EXMEM, rd_EXMEM, regWrite_EXMEM, zero_EXMEM
   );
endinterface

// File: rtl/exec_pipelined.sv
// exec_pipelined
//   Execute stage with registered EX/MEM output: two-source operand forwarding,
//   add/sub/and/or/slt ALU and an optional iterative shift-add multiplier.
//   Ports:
//     clk  clock
//     rst  synchronous active-high reset (priority over flush and in_valid)
//     bus  exec_pipelined_if.slave: ID/EX fields, MEM/WB forwarding source,
//          busy and the EX/MEM register outputs
//   Configuration:
//     EXEC_MUL_EN defined   : aluCtrl 101 multiplies over DATA_W cycles, busy
//                             is high while the multiply is in flight.
//     EXEC_MUL_EN undefined : aluCtrl 101 is reserved (result 0), busy tied 0.
module exec_pipelined #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_W  = 5
) (
   input logic             clk,
   input logic             rst,
   exec_pipelined_if.slave bus
);

   // EX/MEM register
   logic              valid_q, valid_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic [REG_W-1:0]  rd_q, rd_d;
   logic              regwr_q, regwr_d;
   logic              zero_q, zero_d;

   logic              busy;
   logic              accept;
   logic              fwd_ex_a, fwd_wb_a, fwd_ex_b, fwd_wb_b;
   logic [DATA_W-1:0] op_a, rt_val, op_b, alu_res;

   // EX/MEM beats MEM/WB because it holds the younger value.
   assign fwd_ex_a = valid_q & regwr_q & (rd_q != '0) & (rd_q == bus.rs_IDEX);
   assign fwd_wb_a = bus.regWrite_MEMWB & (bus.rd_MEMWB != '0) & (bus.rd_MEMWB == bus.rs_IDEX);
   assign fwd_ex_b = valid_q & regwr_q & (rd_q != '0) & (rd_q == bus.rt_IDEX);
   assign fwd_wb_b = bus.regWrite_MEMWB & (bus.rd_MEMWB != '0) & (bus.rd_MEMWB == bus.rt_IDEX);

   always_comb begin
      op_a = bus.readData1;
      if (fwd_ex_a) begin
         op_a = result_q;
      end else if (fwd_wb_a) begin
         op_a = bus.valueToWB;
      end
   end

   always_comb begin
      rt_val = bus.readData2;
      if (fwd_ex_b) begin
         rt_val = result_q;
      end else if (fwd_wb_b) begin
         rt_val = bus.valueToWB;
      end
   end

   // The immediate is selected after forwarding so it can never be overridden.
   assign op_b = bus.ctrlAluSrc ? bus.address : rt_val;

   always_comb begin
      alu_res = '0;
      case (bus.aluCtrl)
         3'b000:  alu_res = op_a + op_b;
         3'b001:  alu_res = op_a - op_b;
         3'b010:  alu_res = op_a & op_b;
         3'b011:  alu_res = op_a | op_b;
         3'b100:  alu_res[0] = $signed(op_a) < $signed(op_b);
         // 101 goes to the multiplier when present; 11x reserved.
         default: alu_res = '0;
      endcase
   end

   assign accept = bus.in_valid & ~busy & ~bus.flush;

`ifdef EXEC_MUL_EN
   localparam int unsigned     CntW    = $clog2(DATA_W);
   localparam logic [CntW-1:0] CntLast = CntW'(DATA_W - 1);

   typedef enum logic [0:0] {StIdle, StMul} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0] mcand_q, mcand_d;
   logic [DATA_W-1:0] mplier_q, mplier_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [REG_W-1:0]  mrd_q, mrd_d;
   logic              mregwr_q, mregwr_d;
   logic [DATA_W-1:0] prod;
   logic              is_mul;

   assign is_mul = (bus.aluCtrl == 3'b101);
   assign busy   = (state_q == StMul);
   // Multiplicand shifts left and multiplier shifts right each step, so only
   // bit 0 of the multiplier is ever inspected.
   assign prod   = acc_q + (mplier_q[0] ? mcand_q : '0);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      mrd_d    = mrd_q;
      mregwr_d = mregwr_q;
      valid_d  = 1'b0;
      result_d = result_q;
      rd_d     = rd_q;
      regwr_d  = regwr_q;
      zero_d   = zero_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (is_mul) begin
                  state_d  = StMul;
                  cnt_d    = '0;
                  acc_d    = '0;
                  mcand_d  = op_a;
                  mplier_d = op_b;
                  mrd_d    = bus.rd_IDEX;
                  mregwr_d = bus.regWrite_IDEX;
               end else begin
                  valid_d  = 1'b1;
                  result_d = alu_res;
                  rd_d     = bus.rd_IDEX;
                  regwr_d  = bus.regWrite_IDEX;
                  zero_d   = (alu_res == '0);
               end
            end
         end
         StMul: begin
            if (bus.flush) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else begin
               acc_d    = prod;
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
               cnt_d    = cnt_q + CntW'(1);
               if (cnt_q == CntLast) begin
                  state_d  = StIdle;
                  cnt_d    = '0;
                  valid_d  = 1'b1;
                  result_d = prod;
                  rd_d     = mrd_q;
                  regwr_d  = mregwr_q;
                  zero_d   = (prod == '0);
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         mrd_q    <= '0;
         mregwr_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         mrd_q    <= mrd_d;
         mregwr_q <= mregwr_d;
      end
   end
`else
   assign busy = 1'b0;

   always_comb begin
      valid_d  = 1'b0;
      result_d = result_q;
      rd_d     = rd_q;
      regwr_d  = regwr_q;
      zero_d   = zero_q;
      if (accept) begin
         valid_d  = 1'b1;
         result_d = alu_res;
         rd_d     = bus.rd_IDEX;
         regwr_d  = bus.regWrite_IDEX;
         zero_d   = (alu_res == '0);
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q  <= 1'b0;
         result_q <= '0;
         rd_q     <= '0;
         regwr_q  <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         valid_q  <= valid_d;
         result_q <= result_d;
         rd_q     <= rd_d;
         regwr_q  <= regwr_d;
         zero_q   <= zero_d;
      end
   end

   assign bus.busy           = busy;
   assign bus.valid_EXMEM    = valid_q;
   assign bus.result_EXMEM   = result_q;
   assign bus.rd_EXMEM       = rd_q;
   assign bus.regWrite_EXMEM = regwr_q;
   assign bus.zero_EXMEM     = zero_q;

endmodule
